// File: rtl/dm_access_ctl.sv
// -----------------------------------------------------------------------------
// dm_access_ctl -- data-memory access controller
//
// Sits directly upstream of the bus-connect stage.
//   - Load/store requests arrive from the program sequencer.
//   - Access addresses arrive from the DAG.
//   - Store data arrives from the bus.
// The block runs a registered memory handshake with DM_WAIT wait states. It
// stalls the sequencer while an access is still counting down its wait states.
// The most recent load result is held on dm_bc_dt for the bus-connect input mux.
//
// Parameters
//   DW       data width (store data, load data, memory data)
//   AW       data-memory word-address width
//   DM_WAIT  wait states per access, 0..15 (0 = zero-wait memory)
//
// Optional feature (compile-time macro)
//   DM_FWD_EN  one-entry store buffer (last write address/data plus a valid bit).
//              A load-only request that hits the buffer completes at the next
//              edge, whatever DM_WAIT is. The hit never raises dm_mem_re and
//              never stalls. Without the macro, every load goes to memory.
//
// Ports
//   clk          in   system clock, all state on the rising edge
//   reset        in   synchronous, active-high reset
//   ps_dm_rd_en  in   load request; held by the sequencer while dm_ps_stall=1
//   ps_dm_wr_en  in   store request; held by the sequencer while dm_ps_stall=1
//   dg_dm_add    in   [AW] access address from the DAG
//   bc_dm_dt     in   [DW] store data from the bus
//   mem_dm_rdt   in   [DW] memory read data, valid at the completion edge
//   dm_mem_add   out  [AW] registered memory address
//   dm_mem_wdt   out  [DW] registered memory write data
//   dm_mem_re    out  registered memory read strobe
//   dm_mem_we    out  registered memory write strobe
//   dm_bc_dt     out  [DW] last load result, to bus connect
//   dm_ps_stall  out  combinational stall to the sequencer
//   dm_ps_err    out  one-cycle pulse: load and store requested together
//
// Handshake: the sequencer presents a request and keeps it steady while
// dm_ps_stall is high. A request is taken at the first rising edge where
// dm_ps_stall is low. That happens when the controller is idle, or when it is
// on the completion cycle of the previous access, so back-to-back accesses run
// with no bubble. Request inputs sampled while dm_ps_stall is high are ignored.
// -----------------------------------------------------------------------------
module dm_access_ctl #(
  parameter int DW      = 16,
  parameter int AW      = 14,
  parameter int DM_WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps_dm_rd_en,
  input  logic          ps_dm_wr_en,
  input  logic [AW-1:0] dg_dm_add,
  input  logic [DW-1:0] bc_dm_dt,
  input  logic [DW-1:0] mem_dm_rdt,
  output logic [AW-1:0] dm_mem_add,
  output logic [DW-1:0] dm_mem_wdt,
  output logic          dm_mem_re,
  output logic          dm_mem_we,
  output logic [DW-1:0] dm_bc_dt,
  output logic          dm_ps_stall,
  output logic          dm_ps_err
);

  // Wait-state reload value. DM_WAIT is limited to 0..15 so that it fits the
  // 4-bit counter.
  localparam logic [3:0] WAIT_INIT = 4'(DM_WAIT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] wcnt;

  logic req;       // any request present this cycle
  logic rd_only;   // load without a simultaneous store
  logic accept;    // a request sampled at this edge is taken
  logic complete;  // the current access finishes at this edge
  logic fwd_hit;   // load served from the store buffer instead of memory

  assign req      = ps_dm_rd_en | ps_dm_wr_en;
  assign rd_only  = ps_dm_rd_en & ~ps_dm_wr_en;
  assign accept   = (state == ST_IDLE) || (wcnt == 4'd0);
  assign complete = (state == ST_ACC) && (wcnt == 4'd0);

  // The sequencer is held only while wait states remain. On the completion
  // cycle stall is already low, so the next request is taken on that same
  // edge. With DM_WAIT=0 the stall never asserts.
  assign dm_ps_stall = (state == ST_ACC) && (wcnt != 4'd0);

`ifdef DM_FWD_EN
  logic [AW-1:0] sb_add;
  logic [DW-1:0] sb_dt;
  logic          sb_vld;
  logic          fwd_pend;  // the access in flight is a store-buffer hit

  assign fwd_hit = rd_only && sb_vld && (dg_dm_add == sb_add);

  // Every accepted store refreshes the buffer, including a store that arrives
  // together with a load. A hit that completes on the same edge as a new store
  // is accepted still sees the old buffer contents, so it returns the data
  // that was current when the load was issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_add <= '0;
      sb_dt  <= '0;
      sb_vld <= 1'b0;
    end else if (accept && ps_dm_wr_en) begin
      sb_add <= dg_dm_add;
      sb_dt  <= bc_dm_dt;
      sb_vld <= 1'b1;
    end
  end
`else
  assign fwd_hit = 1'b0;
`endif

  // Access FSM. All memory-side outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      // An access in flight is dropped. Its strobes fall on the next cycle and
      // nothing is captured into dm_bc_dt.
      state      <= ST_IDLE;
      wcnt       <= 4'd0;
      dm_mem_add <= '0;
      dm_mem_wdt <= '0;
      dm_mem_re  <= 1'b0;
      dm_mem_we  <= 1'b0;
      dm_bc_dt   <= '0;
      dm_ps_err  <= 1'b0;
`ifdef DM_FWD_EN
      fwd_pend   <= 1'b0;
`endif
    end else begin
      dm_ps_err <= 1'b0;

      // Load capture on the completion edge. The read strobe doubles as the
      // "pending op is a memory read" flag, so stores never touch dm_bc_dt.
      if (complete && dm_mem_re) begin
        dm_bc_dt <= mem_dm_rdt;
      end
`ifdef DM_FWD_EN
      if (complete && fwd_pend) begin
        dm_bc_dt <= sb_dt;
      end
`endif

      if (!accept) begin
        // Wait states: the strobes, address and write data stay put.
        wcnt <= wcnt - 4'd1;
      end else if (req) begin
        state      <= ST_ACC;
        wcnt       <= fwd_hit ? 4'd0 : WAIT_INIT;
        dm_mem_add <= dg_dm_add;
        // A combined load+store performs the store only and flags the error.
        dm_mem_re  <= rd_only & ~fwd_hit;
        dm_mem_we  <= ps_dm_wr_en;
        dm_ps_err  <= ps_dm_rd_en & ps_dm_wr_en;
        if (ps_dm_wr_en) begin
          dm_mem_wdt <= bc_dm_dt;
        end
`ifdef DM_FWD_EN
        fwd_pend   <= fwd_hit;
`endif
      end else if (state == ST_ACC) begin
        // Completion with no follow-on request.
        state     <= ST_IDLE;
        dm_mem_re <= 1'b0;
        dm_mem_we <= 1'b0;
`ifdef DM_FWD_EN
        fwd_pend  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dm_access_ctl.sv
// -----------------------------------------------------------------------------
// tb_dm_access_ctl -- bench for dm_access_ctl
//
// Three instances share one clock and one reset: DM_WAIT = 0, 2 and 3.
//
// A memory responder returns the bench's reference contents for the address
// each instance presents. Unwritten words read as {2'b00,addr} ^ 16'hBFCC, so
// address 0x0123 returns 0xBEEF.
//
// Handshake: requests are driven just after a falling edge. A request is taken
// at the next rising edge if the bench's own model says the previous access is
// on its last cycle. It is then held, with its address and data scrambled,
// through the wait states.
//
// Scoreboard: each load pushes its expected result and due cycle. A monitor
// compares every instance's dm_bc_dt at every falling edge against the last
// expected load result.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dm_access_ctl;
  localparam int DW = 16;
  localparam int AW = 14;
  localparam int NI = 3;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT wiring
  logic [NI-1:0] rd_en;
  logic [NI-1:0] wr_en;
  logic [AW-1:0] dg_add  [NI];
  logic [DW-1:0] bc_dt   [NI];
  logic [DW-1:0] mem_rdt [NI];
  logic [AW-1:0] mem_add [NI];
  logic [DW-1:0] mem_wdt [NI];
  logic [NI-1:0] mem_re;
  logic [NI-1:0] mem_we;
  logic [NI-1:0] stall;
  logic [NI-1:0] err;
  logic [DW-1:0] bc_out  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dm_access_ctl #(
      .DW(DW),
      .AW(AW),
      .DM_WAIT(g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .ps_dm_rd_en (rd_en[g]),
      .ps_dm_wr_en (wr_en[g]),
      .dg_dm_add   (dg_add[g]),
      .bc_dm_dt    (bc_dt[g]),
      .mem_dm_rdt  (mem_rdt[g]),
      .dm_mem_add  (mem_add[g]),
      .dm_mem_wdt  (mem_wdt[g]),
      .dm_mem_re   (mem_re[g]),
      .dm_mem_we   (mem_we[g]),
      .dm_bc_dt    (bc_out[g]),
      .dm_ps_stall (stall[g]),
      .dm_ps_err   (err[g])
    );
  end

  function automatic int wait_of(input int g);
    case (g)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  // ---------------------------------------------------------------- bookkeeping
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic rst_s  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference memory/models
  logic [DW-1:0] ref_mem [int];
  logic          buf_v    [NI];
  logic [AW-1:0] buf_a    [NI];
  logic [DW-1:0] last_wdt [NI];

  function automatic logic [DW-1:0] mem_lookup(input int g, input logic [AW-1:0] a);
    int key;
    key = g * 65536 + int'(a);
    if (ref_mem.exists(key)) return ref_mem[key];
    return {2'b00, a} ^ 16'hBFCC;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < NI; g++) begin
      buf_v[g]    = 1'b0;
      buf_a[g]    = '0;
      last_wdt[g] = '0;
    end
  endtask

  // Memory responder: reads are settled shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) mem_rdt[g] = mem_lookup(g, mem_add[g]);
    end
  end

  // ---------------------------------------------------------------- scoreboard
  logic [DW-1:0] exp_q  [$];
  int            due_q  [$];
  int            inst_q [$];
  logic [DW-1:0] hold   [NI];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      rst_s = reset;
    end
  end

  initial begin
    for (int g = 0; g < NI; g++) hold[g] = '0;
    forever begin
      @(negedge clk);
      if (rst_s) begin
        for (int g = 0; g < NI; g++) hold[g] = '0;
        exp_q.delete();
        due_q.delete();
        inst_q.delete();
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        int gi;
        gi = inst_q.pop_front();
        void'(due_q.pop_front());
        hold[gi] = exp_q.pop_front();
      end
      for (int g = 0; g < NI; g++) check($sformatf("bc_dt[%0d]", g), 32'(bc_out[g]), 32'(hold[g]));
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic drive(input int g, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_en     = '0;
    wr_en     = '0;
    rd_en[g]  = rd;
    wr_en[g]  = wr;
    dg_add[g] = a;
    bc_dt[g]  = d;
  endtask

  // Called just after a falling edge, when the model says that instance g will
  // take a request at the next rising edge. Returns on the falling edge where
  // the next request may be driven.
  task automatic issue(input int g, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp_ld);
    int   w;
    logic hit;
    w   = wait_of(g);
    hit = 1'b0;
`ifdef DM_FWD_EN
    hit = rd && !wr && buf_v[g] && (buf_a[g] == a);
`endif
    if (hit) w = 0;
    if (wr) begin
      ref_mem[g * 65536 + int'(a)] = d;
      last_wdt[g] = d;
      buf_v[g]    = 1'b1;
      buf_a[g]    = a;
    end
    drive(g, rd, wr, a, d);
    if (rd && !wr) begin
      exp_q.push_back(exp_ld);
      due_q.push_back(cyc + w + 2);
      inst_q.push_back(g);
    end
    for (int k = 0; k <= w; k++) begin
      @(negedge clk);
      check($sformatf("stall[%0d]", g), 32'(stall[g]), 32'(k < w));
      check($sformatf("re[%0d]", g), 32'(mem_re[g]), 32'(rd & ~wr & ~hit));
      check($sformatf("we[%0d]", g), 32'(mem_we[g]), 32'(wr));
      check($sformatf("err[%0d]", g), 32'(err[g]), 32'((k == 0) && rd && wr));
      check($sformatf("add[%0d]", g), 32'(mem_add[g]), 32'(a));
      check($sformatf("wdt[%0d]", g), 32'(mem_wdt[g]), 32'(last_wdt[g]));
      if (k < w) begin
        // Sampled while stalled, so the DUT must ignore these.
        dg_add[g] = AW'($urandom);
        bc_dt[g]  = DW'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    rd_en = '0;
    wr_en = '0;
    repeat (n) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        check($sformatf("idle_re[%0d]", g), 32'(mem_re[g]), 32'd0);
        check($sformatf("idle_we[%0d]", g), 32'(mem_we[g]), 32'd0);
        check($sformatf("idle_stall[%0d]", g), 32'(stall[g]), 32'd0);
        check($sformatf("idle_err[%0d]", g), 32'(err[g]), 32'd0);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s_add[%0d]", tag, g), 32'(mem_add[g]), 32'd0);
      check($sformatf("%s_wdt[%0d]", tag, g), 32'(mem_wdt[g]), 32'd0);
      check($sformatf("%s_re[%0d]", tag, g), 32'(mem_re[g]), 32'd0);
      check($sformatf("%s_we[%0d]", tag, g), 32'(mem_we[g]), 32'd0);
      check($sformatf("%s_bc[%0d]", tag, g), 32'(bc_out[g]), 32'd0);
      check($sformatf("%s_stall[%0d]", tag, g), 32'(stall[g]), 32'd0);
      check($sformatf("%s_err[%0d]", tag, g), 32'(err[g]), 32'd0);
    end
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int            g;
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_ld;  // expected load result (loads only)
    logic          gap;     // go idle afterwards and check the strobes drop
  } vec_t;

  vec_t tbl [12];

  // ---------------------------------------------------------------- main sequence
  initial begin
    tbl[0]  = '{1, 1'b1, 1'b0, 14'h0123, 16'h0000, 16'hBEEF, 1'b1};  // W2 read, mem 0xBEEF
    tbl[1]  = '{0, 1'b0, 1'b1, 14'h0010, 16'h5A5A, 16'h0000, 1'b0};  // W0 write
    tbl[2]  = '{0, 1'b1, 1'b0, 14'h0010, 16'h0000, 16'h5A5A, 1'b0};  // W0 read-after-write
    tbl[3]  = '{0, 1'b1, 1'b0, 14'h0011, 16'h0000, 16'hBFDD, 1'b1};
    tbl[4]  = '{1, 1'b1, 1'b1, 14'h0200, 16'h1111, 16'h0000, 1'b0};  // rd&wr together
    tbl[5]  = '{1, 1'b1, 1'b0, 14'h0200, 16'h0000, 16'h1111, 1'b0};
    tbl[6]  = '{1, 1'b0, 1'b1, 14'h3FFF, 16'hFFFF, 16'h0000, 1'b0};  // top address
    tbl[7]  = '{1, 1'b1, 1'b0, 14'h3FFF, 16'h0000, 16'hFFFF, 1'b0};
    tbl[8]  = '{1, 1'b1, 1'b0, 14'h0000, 16'h0000, 16'hBFCC, 1'b1};
    tbl[9]  = '{2, 1'b0, 1'b1, 14'h0040, 16'h1234, 16'h0000, 1'b0};  // W3 write
    tbl[10] = '{2, 1'b1, 1'b0, 14'h0040, 16'h0000, 16'h1234, 1'b0};  // W3 read same address
    tbl[11] = '{2, 1'b1, 1'b0, 14'h0041, 16'h0000, 16'hBF8D, 1'b1};

    model_reset();
    rd_en = '0;
    wr_en = '0;
    for (int g = 0; g < NI; g++) begin
      dg_add[g] = '0;
      bc_dt[g]  = '0;
    end

    // Power-on reset.
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("por");
    end
    reset = 1'b0;
    idle(2);

    // Table-driven accesses.
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].g, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].exp_ld);
      if (tbl[i].gap) idle(2);
    end

    // Reset held for 3 cycles in the middle of a W2 store.
    drive(1, 1'b0, 1'b1, 14'h0050, 16'hCAFE);
    @(negedge clk);
    check("mid_we", 32'(mem_we[1]), 32'd1);
    check("mid_wdt", 32'(mem_wdt[1]), 32'hCAFE);
    check("mid_stall", 32'(stall[1]), 32'd1);
    reset = 1'b1;
    rd_en = '0;
    wr_en = '0;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("mid_rst");
    end
    reset = 1'b0;
    model_reset();
    idle(2);

    // Reset during the second wait cycle of a W3 load: the load is lost.
    drive(2, 1'b1, 1'b0, 14'h0300, 16'h0000);
    @(negedge clk);
    check("w3_re0", 32'(mem_re[2]), 32'd1);
    check("w3_stall0", 32'(stall[2]), 32'd1);
    @(negedge clk);
    check("w3_stall1", 32'(stall[2]), 32'd1);
    reset = 1'b1;
    rd_en = '0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("w3_rst_re", 32'(mem_re[2]), 32'd0);
    check("w3_rst_stall", 32'(stall[2]), 32'd0);
    idle(6);
    issue(2, 1'b1, 1'b0, 14'h0300, 16'h0000, 16'hBCCC);
    idle(2);

    // Random traffic over a few addresses so that rewrites and buffer hits occur.
    for (int i = 0; i < 40; i++) begin
      int            g;
      int            sel;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      g   = $urandom_range(0, NI - 1);
      sel = $urandom_range(0, 3);
      a   = 14'h0100 + AW'($urandom_range(0, 3));
      d   = DW'($urandom);
      issue(g, sel != 2, sel >= 2, a, d, mem_lookup(g, a));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(4);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

endmodule
